// File: rtl/fetch_pkg.sv
// Shared constants and FSM state type for the instruction fetch stage.
package fetch_pkg;
  localparam int OPCODE_W   = 6;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int INSTR_W    = 32;
  localparam int PC_STEP    = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP,
    HALT
  } fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO with flush; head is a registered slot, push-to-visible latency 1 cycle.
// A push into a full FIFO is accepted only alongside a pop; flush beats push and pop.
module fetch_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head_data
);
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: one outstanding imem read, 2-entry buffer to the decoder, redirect flushes wrong path.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky fetch_fault and halts fetch.
import fetch_pkg::*;

module instr_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   pc_plus4,
  output logic                fetch_fault
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_t                state;
  logic [ADDR_W-1:0]           pc;
  logic [ADDR_W-1:0]           req_pc;
  logic [ADDR_W-1:0]           redir_tgt;
  logic                        gnt_ok;
  logic                        push;
  logic                        pop;
  logic                        misalign;
  logic [1:0]                  count;
  logic [INSTR_W+ADDR_W-1:0]   head;

  assign pop       = instr_valid && instr_ready;
  // Space is checked at issue time so the eventual response always has a slot.
  assign imem_req  = (state == REQ) && ((count != 2'd2) || pop);
  assign imem_addr = pc;
  assign gnt_ok    = imem_req && imem_gnt;
  assign redir_tgt = redirect_pc & ~ADDR_W'(3);
  assign push      = (state == WAIT) && imem_rvalid && !redirect_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  assign misalign    = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && misalign && (state != HALT)) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign misalign    = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (redirect_valid && (state != HALT)) begin
      if (misalign) begin
        state <= HALT;
      end else begin
        pc <= redir_tgt;
        // A granted or still-pending read belongs to the old path and must be drained.
        case (state)
          REQ:     state <= gnt_ok ? DROP : REQ;
          WAIT:    state <= imem_rvalid ? REQ : DROP;
          DROP:    state <= DROP;
          default: state <= REQ;
        endcase
      end
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (gnt_ok) begin
            pc     <= pc + STEP;
            req_pc <= pc;
            state  <= WAIT;
          end
        end
        WAIT:    if (imem_rvalid) state <= REQ;
        DROP:    if (imem_rvalid) state <= REQ;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH(INSTR_W + ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({imem_rdata, req_pc}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_data (head)
  );

  assign instr_valid = (count != 2'd0);
  assign instr       = head[INSTR_W+ADDR_W-1:ADDR_W];
  assign instr_pc    = head[ADDR_W-1:0];
  assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
  assign pc_plus4    = instr_pc + STEP;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a reactive instruction-memory model.
module tb_instr_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  logic [3:0]  lat;
  logic [3:0]  cnt;
  logic [3:0]  c_next;
  logic [31:0] paddr;

  instr_fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .pc_plus4       (pc_plus4),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0000;
      32'h4:   return 32'h18A5_0001;
      32'h8:   return 32'h2000_0003;
      default: return 32'hC000_0000 | a;
    endcase
  endfunction

  // Memory: response 'lat' cycles after the grant edge.
  assign c_next = (imem_req && imem_gnt) ? lat : ((cnt != 4'd0) ? cnt - 4'd1 : 4'd0);

  always @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= 4'd0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
      paddr       <= 32'h0;
    end else begin
      cnt         <= c_next;
      imem_rvalid <= (c_next == 4'd1);
      if (imem_req && imem_gnt) paddr <= imem_addr;
      imem_rdata  <= word((imem_req && imem_gnt) ? imem_addr : paddr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b1;
    lat            = 4'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] epc,
                              input logic [31:0] ein, input logic [5:0] eop);
    int n;
    n = 0;
    while (!instr_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, instr_pc, epc);
    chk({tag, "_instr"}, instr, ein);
    chk({tag, "_opc"}, 32'(opcode), 32'(eop));
    chk({tag, "_pc4"}, pc_plus4, epc + 32'd4);
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] eaddr, input int bound);
    int   n;
    logic saw;
    n   = 0;
    saw = 1'b0;
    while (!imem_req && n < bound) begin
      saw = saw | instr_valid;
      @(negedge clk);
      n++;
    end
    saw = saw | instr_valid;
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    chk({tag, "_addr"}, imem_addr, eaddr);
    chk({tag, "_nowrong"}, 32'(saw), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b1;
    lat            = 4'd1;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_vld", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_opc", 32'(opcode), 32'd0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_fault", 32'(fetch_fault), 32'd0);

    // Streaming with 1-cycle memory and an always-ready decoder.
    apply_reset();
    @(negedge clk);
    chk("t1_req0", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    @(negedge clk);
    chk("t1_early_vld", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("t1_first_vld", 32'(instr_valid), 32'd1);
    expect_instr("t1_w0", 32'h0, 32'h0000_0000, 6'b000000);
    expect_instr("t1_w1", 32'h4, 32'h18A5_0001, 6'b000110);
    expect_instr("t1_w2", 32'h8, 32'h2000_0003, 6'b001000);

    // Backpressure: buffer fills with two words, then requests stop.
    instr_ready = 1'b0;
    apply_reset();
    repeat (10) @(negedge clk);
    chk("t2_req_off", 32'(imem_req), 32'd0);
    chk("t2_vld", 32'(instr_valid), 32'd1);
    chk("t2_head_pc", instr_pc, 32'h0);
    chk("t2_head_instr", instr, 32'h0);
    instr_ready = 1'b1;
    #1;
    chk("t2_resume_req", 32'(imem_req), 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h8);
    expect_instr("t2_w0", 32'h0, 32'h0000_0000, 6'b000000);
    expect_instr("t2_w1", 32'h4, 32'h18A5_0001, 6'b000110);
    expect_instr("t2_w2", 32'h8, 32'h2000_0003, 6'b001000);

    // Redirect while waiting; stale response shows up three cycles later.
    apply_reset();
    lat = 4'd4;
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t3_drop_req", 32'(imem_req), 32'd0);
    wait_req("t3", 32'h100, 8);
    lat = 4'd1;
    expect_instr("t3_w", 32'h100, 32'hC000_0100, 6'b110000);

    // Redirect in the same cycle as the grant.
    apply_reset();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_req("t4a", 32'h200, 6);
    expect_instr("t4a_w", 32'h200, 32'hC000_0200, 6'b110000);

    // Redirect in the same cycle as the response.
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4b_req", 32'(imem_req), 32'd1);
    chk("t4b_addr", imem_addr, 32'h300);
    chk("t4b_vld", 32'(instr_valid), 32'd0);
    expect_instr("t4b_w", 32'h300, 32'hC000_0300, 6'b110000);

    // PC wraps past the top of the address space.
    apply_reset();
    @(negedge clk);
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_gnt       = 1'b1;
    chk("t5_req_top", 32'(imem_req), 32'd1);
    chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    @(negedge clk);
    chk("t5_req_wrap", 32'(imem_req), 32'd1);
    chk("t5_addr_wrap", imem_addr, 32'h0);
    expect_instr("t5_wtop", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 6'b111111);
    expect_instr("t5_wzero", 32'h0, 32'h0000_0000, 6'b000000);

    // Redirect flushes a full buffer.
    instr_ready = 1'b0;
    apply_reset();
    repeat (6) @(negedge clk);
    chk("t6_full_vld", 32'(instr_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t6_flushed", 32'(instr_valid), 32'd0);
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", imem_addr, 32'h400);
    instr_ready = 1'b1;
    expect_instr("t6_w", 32'h400, 32'hC000_0400, 6'b110000);

    // Misaligned redirect target.
    apply_reset();
    @(negedge clk);
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_gnt       = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t7_fault", 32'(fetch_fault), 32'd1);
    chk("t7_req_off", 32'(imem_req), 32'd0);
    repeat (5) @(negedge clk);
    chk("t7_req_held", 32'(imem_req), 32'd0);
    chk("t7_fault_sticky", 32'(fetch_fault), 32'd1);
    chk("t7_vld", 32'(instr_valid), 32'd0);
`else
    chk("t7_req", 32'(imem_req), 32'd1);
    chk("t7_addr", imem_addr, 32'h100);
    chk("t7_fault", 32'(fetch_fault), 32'd0);
`endif
    apply_reset();
    chk("t7_fault_clr", 32'(fetch_fault), 32'd0);
    chk("t7_vld_clr", 32'(instr_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

- Fetch stage directly upstream of the opcode decoder in the single-cycle datapath.
- Holds the PC and issues word reads to instruction memory over a request/grant/response handshake.
- Buffers returned words in a 2-entry FIFO and presents instruction, PC and the 6-bit opcode field to the decoder with valid/ready.
- Accepts redirects (branch/jump targets computed downstream) and discards wrong-path words.

## Interface
- ADDR_W, 32, PC and memory address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- imem_req  out  1  read request valid
- imem_addr  out  ADDR_W  read address (word-aligned)
- imem_gnt  in  1  request accepted this cycle when imem_req=1
- imem_rvalid  in  1  read data valid; exactly one per grant, in order, ≥1 cycle after grant
- imem_rdata  in  32  read data
- redirect_valid  in  1  load new PC this cycle (taken branch or jump)
- redirect_pc  in  ADDR_W  redirect target
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decoder consumes head
- instr  out  32  head instruction word
- instr_pc  out  ADDR_W  address of head instruction
- opcode  out  6  instr[31:26], feeds decoder opcode input
- pc_plus4  out  ADDR_W  instr_pc+4, for branch/jump target arithmetic
- fetch_fault  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- States:
  - IDLE: reset state; always goes to REQ the next cycle.
  - REQ: imem_req=1 when FIFO has space (count<2, or a pop occurs this cycle); imem_addr=pc. On imem_gnt: pc<=pc+4, save pc as req_pc, go to WAIT.
  - WAIT: on imem_rvalid, push {imem_rdata, req_pc} and go to REQ.
  - DROP: wait for the stale response. On imem_rvalid, discard it and go to REQ.
  - HALT: only with the macro; see Configuration.
- At most one request outstanding. Space is checked at issue, so a response always has a FIFO slot.
- Pop when instr_valid && instr_ready. Push and pop in the same cycle are legal; count is unchanged.
- Redirect has priority over every other event in the same cycle:
  - pc<=redirect_pc; FIFO flushed (count<=0, pop ignored).
  - REQ without gnt: stay in REQ.
  - REQ with gnt: go to DROP; pc still takes redirect_pc.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid: data discarded, go to REQ.
  - DROP: stay in DROP.
- PC arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.
- opcode and pc_plus4 are combinational from the FIFO head registers.
- When instr_valid=0, instr, instr_pc and opcode hold stale head-slot contents.

## Timing
- Reset (rst_n=0 at an edge): pc=RESET_PC, state=IDLE, FIFO empty, fetch_fault=0.
- Reset output values: imem_req=0, instr_valid=0, instr=0, instr_pc=0, opcode=0, pc_plus4=4.
- rst_n low mid-transaction aborts everything. A response arriving during reset, or in IDLE, is ignored.
- Memory with 1-cycle latency, decoder always ready:
  - one instruction per 2 cycles (REQ, WAIT);
  - first instr_valid 3 cycles after rst_n rises.
- Redirect at edge N: imem_req with imem_addr=redirect_pc in cycle N+1 (from REQ or WAIT+rvalid). instr_valid=0 in cycle N+1 at the latest.
- instr, instr_pc and opcode are stable while instr_valid=1 and instr_ready=0.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - redirect_pc[1:0]≠0 sets fetch_fault=1 (sticky) and enters HALT.
  - FIFO is flushed; no requests are issued until reset.
  - An outstanding response is ignored.
- FETCH_ALIGN_CHECK_EN undefined:
  - redirect_pc[1:0] is forced to 2'b00 silently.
  - fetch_fault is tied to 0; there is no HALT state.

## Structure
- Package fetch_pkg:
  - OPCODE_W=6, OPCODE_MSB=31, OPCODE_LSB=26;
  - INSTR_W=32, PC_STEP=4;
  - fetch_state_t enum {IDLE, REQ, WAIT, DROP, HALT}.
- Sub-module fetch_fifo: 2-entry, width INSTR_W+ADDR_W, with push/pop/flush, count, head outputs. Flush has priority over push and pop.

## Test plan
- Reset release, memory returns 32'h0000_0000, 32'h18A5_0001, 32'h2000_0003 at 0,4,8 with 1-cycle latency, ready=1 -> instr_pc 0,4,8 in order; opcode 6'b000000, 6'b000110, 6'b001000.
- Hold instr_ready=0 for 10 cycles -> exactly 2 words buffered, imem_req=0 thereafter, head stable; release -> both drained in order, fetch resumes at pc 8.
- Redirect to 32'h100 in WAIT without rvalid, response arrives 3 cycles later -> response discarded, next imem_addr=32'h100, first instr_pc=32'h100.
- Redirect coincident with imem_gnt and with rvalid (separate runs) -> no wrong-path word ever has instr_valid=1; next address is redirect_pc.
- Redirect to 32'hFFFF_FFFC -> next fetch addresses 32'hFFFF_FFFC then 32'h0.
- Redirect to 32'h102: with FETCH_ALIGN_CHECK_EN, fetch_fault=1, imem_req stays 0 until reset; without it, fetch from 32'h100.
